hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the combinational forwarding units. It merges ALU-operand forwarding, ID-stage branch-operand forwarding and hazard stall generation behind a per-register latency scoreboard. Each register's countdown covers single-cycle ALU ops, loads and multi-cycle (mul/div) results. Sits beside the ID stage, is fed by IF/ID, ID/EX, EX/MEM and MEM/WB pipeline fields, and drives the PC/IF_ID write-enable (stall) and both operand mux selects.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 12 +
 rtl/hazard_scoreboard_unit_if.sv | 43 ++++
 rtl/hazard_scoreboard_unit_fwd_select.sv | 25 ++
 rtl/hazard_scoreboard_unit.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants for the hazard scoreboard: forwarding mux encodings and
// nominal result latencies. Pure definitions, no timing or handshake.
package hazard_scoreboard_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of ID/EX/MEM/WB pipeline fields into the scoreboard and its stall/select outputs.
// master drives the pipeline fields; slave is the scoreboard itself.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3,
  parameter int CNT_W   = 32
);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC-1:0]          id_src_used;
  logic                        id_is_branch;
  logic [REG_AW-1:0]           id_dst_addr;
  logic                        id_dst_we;
  logic [LAT_W-1:0]            id_dst_lat;
  logic [NUM_SRC*REG_AW-1:0]   ex_src_addr;
  logic [REG_AW-1:0]           ex_mem_rd;
  logic                        ex_mem_we;
  logic [REG_AW-1:0]           mem_wb_rd;
  logic                        mem_wb_we;
  logic                        stall;
  logic [NUM_SRC*2-1:0]        ex_fwd_sel;
  logic [NUM_SRC*2-1:0]        id_fwd_sel;
  logic [NUM_REGS-1:0]         sb_busy;
  logic [CNT_W-1:0]            stall_cycles;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_is_branch,
           id_dst_addr, id_dst_we, id_dst_lat,
           ex_src_addr, ex_mem_rd, ex_mem_we, mem_wb_rd, mem_wb_we,
    input  stall, ex_fwd_sel, id_fwd_sel, sb_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_is_branch,
           id_dst_addr, id_dst_we, id_dst_lat,
           ex_src_addr, ex_mem_rd, ex_mem_we, mem_wb_rd, mem_wb_we,
    output stall, ex_fwd_sel, id_fwd_sel, sb_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Operand forwarding select for one source address; purely combinational.
// EX/MEM wins over MEM/WB since it holds the younger result; $0 never forwards.
module hazard_scoreboard_unit_fwd_select
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_we,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_we,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_mem_we && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_we && (mem_wb_rd != '0) && (mem_wb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register latency scoreboard: RAW/WAW stall same cycle (combinational), plus EX and ID forward selects.
// Stall holds the ID instruction; the scoreboard only counts down until the hazard clears.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_scoreboard_unit_if.slave bus
);

  logic [LAT_W-1:0]     cnt     [NUM_REGS];
  logic [LAT_W-1:0]     cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_nxt;
  logic [NUM_REGS-1:0]  busy_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [LAT_W-1:0]     thr;
  logic                 raw_hit;
  logic                 waw_hit;
  logic                 stall_i;
  logic                 issue;
  logic [NUM_SRC*2-1:0] ex_sel;
  logic [NUM_SRC*2-1:0] id_sel;

  // Branch operands are read in ID, so they must wait for the count to fully drain.
  always_comb begin
    thr     = bus.id_is_branch ? '0 : LAT_W'(LAT_ALU);
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] a;
      a = bus.id_src_addr[i*REG_AW +: REG_AW];
      if (bus.id_src_used[i] && (a != '0) && (cnt[a] > thr)) begin
        raw_hit = 1'b1;
      end
    end
    waw_hit = bus.id_dst_we && (cnt[bus.id_dst_addr] > bus.id_dst_lat);
    stall_i = bus.id_valid && (raw_hit || waw_hit);
    issue   = bus.id_valid && !stall_i;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (cnt[r] != '0) begin
        cnt_nxt[r] = cnt[r] - LAT_W'(1);
      end
      if ((r != 0) && issue && bus.id_dst_we && (bus.id_dst_addr == REG_AW'(r))) begin
        cnt_nxt[r] = bus.id_dst_lat;
      end
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      busy_q <= busy_nxt;
      if (stall_i && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_scoreboard_unit_fwd_select #(.REG_AW(REG_AW)) u_ex_sel (
      .src       (bus.ex_src_addr[i*REG_AW +: REG_AW]),
      .ex_mem_rd (bus.ex_mem_rd),
      .ex_mem_we (bus.ex_mem_we),
      .mem_wb_rd (bus.mem_wb_rd),
      .mem_wb_we (bus.mem_wb_we),
      .sel       (ex_sel[2*i +: 2])
    );
    hazard_scoreboard_unit_fwd_select #(.REG_AW(REG_AW)) u_id_sel (
      .src       (bus.id_src_addr[i*REG_AW +: REG_AW]),
      .ex_mem_rd (bus.ex_mem_rd),
      .ex_mem_we (bus.ex_mem_we),
      .mem_wb_rd (bus.mem_wb_rd),
      .mem_wb_we (bus.mem_wb_we),
      .sel       (id_sel[2*i +: 2])
    );
  end

  assign bus.stall        = stall_i;
  assign bus.ex_fwd_sel   = ex_sel;
  assign bus.id_fwd_sel   = id_sel;
  assign bus.sb_busy      = busy_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed pipeline scenarios, then random traffic,
// all checked against a ready-time model (cycle at which each register's result is available).
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int LAT_W    = 3;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard_unit #(
    .REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     total = 0;
  int     bad   = 0;
  int     now   = 0;
  int     avail [NUM_REGS];
  longint exp_sc = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  // Cycles still to wait before register r's result is in EX/MEM-or-later.
  function automatic int remaining(input logic [REG_AW-1:0] r);
    if (r == '0) return 0;
    return (avail[r] > now) ? (avail[r] - now) : 0;
  endfunction

  function automatic logic model_stall();
    logic s;
    s = 1'b0;
    if (bus.id_valid) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        logic [REG_AW-1:0] a;
        int lim;
        a   = bus.id_src_addr[i*REG_AW +: REG_AW];
        lim = bus.id_is_branch ? 0 : 1;
        if (bus.id_src_used[i] && a != 0 && remaining(a) > lim) s = 1'b1;
      end
      if (bus.id_dst_we && remaining(bus.id_dst_addr) > int'(bus.id_dst_lat)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] s);
    if (bus.ex_mem_we && bus.ex_mem_rd != 0 && bus.ex_mem_rd == s) return FWD_EXMEM;
    if (bus.mem_wb_we && bus.mem_wb_rd != 0 && bus.mem_wb_rd == s) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  function automatic logic [NUM_REGS-1:0] model_busy();
    logic [NUM_REGS-1:0] b;
    for (int r = 0; r < NUM_REGS; r++) b[r] = (remaining(REG_AW'(r)) != 0);
    return b;
  endfunction

  // One clock: check all outputs at the falling edge, then advance the model on the rising edge.
  task automatic step(output logic dut_stall);
    logic s;
    @(negedge clk);
    s = model_stall();
    check_val("stall", bus.stall, s);
    for (int i = 0; i < NUM_SRC; i++) begin
      check_val("ex_fwd_sel", bus.ex_fwd_sel[2*i +: 2], model_fwd(bus.ex_src_addr[i*REG_AW +: REG_AW]));
      check_val("id_fwd_sel", bus.id_fwd_sel[2*i +: 2], model_fwd(bus.id_src_addr[i*REG_AW +: REG_AW]));
    end
    check_val("sb_busy", bus.sb_busy, model_busy());
    check_val("stall_cycles", bus.stall_cycles, exp_sc);
    dut_stall = bus.stall;
    @(posedge clk);
    if (s && exp_sc < 64'hFFFF_FFFF) exp_sc++;
    if (bus.id_valid && !s && bus.id_dst_we && bus.id_dst_addr != 0)
      avail[bus.id_dst_addr] = now + 1 + int'(bus.id_dst_lat);
    now++;
    #1;
  endtask

  task automatic set_id(input logic v, input int s0, input int s1, input logic [1:0] used,
                        input logic br, input int dst, input logic we, input int lat);
    bus.id_valid     = v;
    bus.id_src_addr  = {REG_AW'(s1), REG_AW'(s0)};
    bus.id_src_used  = used;
    bus.id_is_branch = br;
    bus.id_dst_addr  = REG_AW'(dst);
    bus.id_dst_we    = we;
    bus.id_dst_lat   = LAT_W'(lat);
  endtask

  task automatic set_pipe(input int e0, input int e1, input int emrd, input logic emwe,
                          input int mwrd, input logic mwwe);
    bus.ex_src_addr = {REG_AW'(e1), REG_AW'(e0)};
    bus.ex_mem_rd   = REG_AW'(emrd);
    bus.ex_mem_we   = emwe;
    bus.mem_wb_rd   = REG_AW'(mwrd);
    bus.mem_wb_we   = mwwe;
  endtask

  // Hold the ID instruction until the DUT lets it issue; returns stall cycles seen.
  task automatic issue_until(output int n);
    logic st;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(st);
      if (!st) return;
      n++;
    end
    check_val("issue_timeout", st, 1'b0);
  endtask

  initial begin
    int   n;
    logic st;
    for (int r = 0; r < NUM_REGS; r++) avail[r] = 0;
    rst_n = 1'b0;
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_pipe(0, 0, 0, 0, 0, 0);
    #3;
    check_val("rst_sb_busy", bus.sb_busy, '0);
    check_val("rst_stall_cycles", bus.stall_cycles, '0);
    check_val("rst_stall", bus.stall, 1'b0);
    @(posedge clk); now++; #1;
    rst_n = 1'b1;

    // add $3 then add reading $3: no stall, forwarded from EX/MEM
    set_id(1, 1, 2, 2'b11, 0, 3, 1, LAT_ALU);
    issue_until(n);
    set_id(1, 3, 0, 2'b01, 0, 8, 1, LAT_ALU);
    set_pipe(1, 2, 0, 0, 0, 0);
    issue_until(n);
    check_val("alu_alu_stalls", n, 0);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_pipe(3, 0, 3, 1, 0, 0);
    #1;
    check_val("alu_alu_ex_fwd", bus.ex_fwd_sel[1:0], FWD_EXMEM);
    step(st);

    // lw $4 then sub reading $4: one bubble, then MEM/WB forward
    set_pipe(0, 0, 0, 0, 0, 0);
    set_id(1, 1, 0, 2'b01, 0, 4, 1, LAT_LOAD);
    issue_until(n);
    set_id(1, 4, 2, 2'b11, 0, 9, 1, LAT_ALU);
    issue_until(n);
    check_val("load_use_stalls", n, 1);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_pipe(4, 2, 0, 0, 4, 1);
    #1;
    check_val("load_use_ex_fwd", bus.ex_fwd_sel[1:0], FWD_MEMWB);
    check_val("load_use_stall_cycles", bus.stall_cycles, 1);
    step(st);

    // lw $5 then beq $5,$0: two bubbles, release reads MEM/WB in ID
    set_pipe(0, 0, 0, 0, 0, 0);
    set_id(1, 1, 0, 2'b01, 0, 5, 1, LAT_LOAD);
    issue_until(n);
    set_id(1, 5, 0, 2'b11, 1, 0, 0, 0);
    step(st);
    check_val("branch_stall_1", st, 1'b1);
    step(st);
    check_val("branch_stall_2", st, 1'b1);
    set_pipe(0, 0, 0, 0, 5, 1);
    #1;
    check_val("branch_release_stall", bus.stall, 1'b0);
    check_val("branch_id_fwd", bus.id_fwd_sel[1:0], FWD_MEMWB);
    step(st);

    // mul $6 (lat 5) then addi $6 (lat 1): WAW hold until the long write is close enough
    set_pipe(0, 0, 0, 0, 0, 0);
    set_id(1, 1, 0, 2'b01, 0, 6, 1, 5);
    issue_until(n);
    set_id(1, 0, 0, 2'b00, 0, 6, 1, LAT_ALU);
    issue_until(n);
    check_val("waw_stalls", n, 4);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    check_val("waw_busy_set", bus.sb_busy[6], 1'b1);
    step(st);
    check_val("waw_busy_clear", bus.sb_busy[6], 1'b0);

    // Both stages write $7: EX/MEM wins. Write to $0 never forwards.
    set_pipe(7, 0, 7, 1, 7, 1);
    #1;
    check_val("fwd_priority", bus.ex_fwd_sel[1:0], FWD_EXMEM);
    step(st);
    set_pipe(0, 0, 0, 1, 0, 0);
    set_id(1, 0, 0, 2'b11, 0, 0, 1, LAT_ALU);
    #1;
    check_val("r0_ex_fwd", bus.ex_fwd_sel, '0);
    check_val("r0_stall", bus.stall, 1'b0);
    step(st);

    // Reset in the middle of a load countdown
    set_pipe(0, 0, 0, 0, 0, 0);
    set_id(1, 1, 0, 2'b01, 0, 4, 1, LAT_LOAD);
    issue_until(n);
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    check_val("pre_rst_busy4", bus.sb_busy[4], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_sb_busy", bus.sb_busy, '0);
    check_val("mid_rst_stall_cycles", bus.stall_cycles, '0);
    for (int r = 0; r < NUM_REGS; r++) avail[r] = 0;
    exp_sc = 0;
    @(posedge clk); now++;
    #2 rst_n = 1'b1;
    set_id(1, 4, 0, 2'b01, 0, 10, 1, LAT_ALU);
    issue_until(n);
    check_val("post_rst_stalls", n, 0);

    // Random traffic on a small register window to provoke frequent hazards
    for (int k = 0; k < 1500; k++) begin
      set_id(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      set_pipe(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step(st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
